imem_responder: RTL and testbench

- Instruction-memory responder at the memory end of the fetch-cache → IMemory interface.
- Watches the word address driven by the instruction cache and returns the addressed 32-bit word after a programmable latency, using the existing mem_addr / mem_dataOut / mem_valid protocol.
- Provides a program-load write port, used by the boot/test harness to preload the instruction image.
- Serves as the synthesizable IMemory model for core and cache bring-up.

---
 rtl/imem_responder.sv | 122 ++++++++++++
 tb/tb_imem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: returns the word addressed by the fetch cache after a
// programmable latency, with a program-load write port for preloading the image.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] OOR_DATA    = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_dataOut,
    output logic        mem_valid,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] req_addr_q, req_addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] dout_q, dout_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [29:0]   cur_word;
    logic [29:0]   ld_word;
    logic          addr_match;
    logic          wr_in_range;
    logic          rd_in_range;
    logic          load_hit;
    logic [31:0]   rd_word;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // Byte-offset bits never take part in addressing.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{mem_addr[1:0], load_addr[1:0]};

    assign cur_word    = mem_addr[31:2];
    assign ld_word     = load_addr[31:2];
    assign addr_match  = (cur_word == req_addr_q);
    assign wr_in_range = (ld_word[29:AW] == '0);
    assign rd_in_range = (req_addr_q[29:AW] == '0);
    assign wr_idx      = ld_word[AW-1:0];
    assign rd_idx      = req_addr_q[AW-1:0];
    assign load_hit    = load_en && wr_in_range && (ld_word == req_addr_q);
    assign rd_word     = rd_in_range ? mem_q[rd_idx] : OOR_DATA;

    // NOTE: the storage array carries no reset so it maps onto plain RAM and the
    // preloaded image survives a core reset.
    always_ff @(posedge clock) begin
        if (load_en && wr_in_range) begin
            mem_q[wr_idx] <= load_data;
        end
    end

    // NOTE: every variable gets its hold value first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        unique case (state_q)
            IDLE: begin
                req_addr_d = cur_word;
                cnt_d      = CNT_INIT;
                state_d    = BUSY;
            end
            BUSY, DONE: begin
                if (!addr_match) begin
                    req_addr_d = cur_word;
                    cnt_d      = CNT_INIT;
                    state_d    = BUSY;
                end else if (load_hit) begin
                    // The word being served was just rewritten: restart so the new
                    // contents are returned with full latency.
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end else if (state_q == BUSY) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        dout_d  = rd_word;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
        end
    end

    // Valid is qualified against the live address so a stale word is never flagged.
    assign mem_valid   = (state_q == DONE) && addr_match;
    assign mem_dataOut = dout_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: a reference memory model feeds a queue of
// expected words that is drained whenever the DUT raises mem_valid.
module tb_imem_responder;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] OOR   = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_dataOut;
    logic        mem_valid;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] expq [$];

    imem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .OOR_DATA   (OOR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_dataOut(mem_dataOut),
        .mem_valid  (mem_valid),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        if (a[31:2] >= 30'(DEPTH)) return OOR;
        return model_mem[a[11:2]];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
        if (a[31:2] < 30'(DEPTH)) model_mem[a[11:2]] = d;
    endtask

    task automatic wait_resp(input string tag, input int exp_ticks);
        int          n;
        logic [31:0] e;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_valid && n < 40);
        check({tag, "_lat"}, 32'(n), 32'(exp_ticks));
        if (expq.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = expq.pop_front();
            check({tag, "_data"}, mem_dataOut, e);
        end
    endtask

    task automatic request(input logic [31:0] a, input string tag);
        mem_addr = a;
        #1;
        check({tag, "_vlo"}, 32'(mem_valid), 32'd0);
        expq.push_back(model_word(a));
        wait_resp(tag, LAT + 1);
    endtask

    task automatic hold_stable(input string tag, input logic [31:0] exp, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check({tag, "_hold_v"}, 32'(mem_valid), 32'd1);
            check({tag, "_hold_d"}, mem_dataOut, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addrs [6];
        int          prev;
        int          k;
        addrs = '{32'h10, 32'h14, 32'h20, 32'h24, 32'h30, 32'h2000};

        reset     = 1'b1;
        mem_addr  = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        repeat (3) tick();
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_data", mem_dataOut, 32'd0);
        reset = 1'b0;

        load(32'h10, 32'hDEAD_BEEF);
        load(32'h14, 32'h0050_0093);
        load(32'h20, 32'h1111_0020);
        load(32'h24, 32'h2222_0024);
        load(32'h30, 32'h3333_0030);

        // Basic read, latency and hold.
        request(32'h10, "t1");
        hold_stable("t1", 32'hDEAD_BEEF, 3);

        // Address change from DONE drops valid in the same cycle.
        request(32'h14, "t2");
        hold_stable("t2", 32'h0050_0093, 1);

        // Abort while BUSY: only the new address may answer.
        mem_addr = 32'h20;
        tick();
        check("t3_busy", 32'(mem_valid), 32'd0);
        request(32'h24, "t3");

        // Byte-offset changes keep the response.
        mem_addr = 32'h26;
        #1;
        check("t3b_off_v", 32'(mem_valid), 32'd1);
        hold_stable("t3b", 32'h2222_0024, 2);

        // Out-of-range read returns the NOP word.
        request(32'h1000, "t4_oor");

        // Load to the word being served restarts the request.
        request(32'h10, "t5_pre");
        load(32'h10, 32'h1234_5678);
        check("t5_vlo", 32'(mem_valid), 32'd0);
        expq.push_back(model_word(32'h10));
        wait_resp("t5", LAT);

        // Loads elsewhere, and dropped out-of-range loads, leave the response alone.
        load(32'h14, 32'h4444_0014);
        check("t6_v", 32'(mem_valid), 32'd1);
        check("t6_d", mem_dataOut, 32'h1234_5678);
        load(32'h1010, 32'hBAD0_BAD0);
        check("t6_oor_v", 32'(mem_valid), 32'd1);
        check("t6_oor_d", mem_dataOut, 32'h1234_5678);
        request(32'h1010, "t6_oor_rd");

        // Load and address change on the same edge.
        mem_addr  = 32'h30;
        load_en   = 1'b1;
        load_addr = 32'h30;
        load_data = 32'hCAFE_0030;
        model_mem[32'h30 >> 2] = 32'hCAFE_0030;
        expq.push_back(model_word(32'h30));
        tick();
        load_en = 1'b0;
        wait_resp("t7", LAT);

        // Reset in the middle of a request; image is preserved.
        mem_addr = 32'h14;
        tick();
        reset = 1'b1;
        tick();
        check("t8_rst_v", 32'(mem_valid), 32'd0);
        check("t8_rst_d", mem_dataOut, 32'd0);
        mem_addr = 32'h10;
        tick();
        check("t8_rst2_d", mem_dataOut, 32'd0);
        reset = 1'b0;
        expq.push_back(model_word(32'h10));
        wait_resp("t8", LAT + 1);

        // Random walk over the loaded image.
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(0, 5));
            if (k == prev) k = (k + 1) % 6;
            prev = k;
            request(addrs[k], "rnd");
        end

        check("sb_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
